// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - command-side controller for the counter block
module counter_cmd_ctrl #(
   parameter int xLen   = 64,
   parameter int RD_LAT = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_funct,
   input  logic [xLen-1:0] cmd_rs1,
   input  logic [4:0]      cmd_rd,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [4:0]      resp_rd,
   output logic [xLen-1:0] resp_data,
   output logic            ctr_init,
   output logic [xLen-1:0] ctr_init_val,
   output logic            ctr_start,
   output logic            ctr_return_current_count,
   input  logic [xLen-1:0] ctr_current_count,
   output logic            busy
);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_RD_WAIT, S_RESP} state_t;

   localparam logic [1:0] OP_INIT  = 2'd0;
   localparam logic [1:0] OP_START = 2'd1;
   localparam logic [1:0] OP_STOP  = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   // Wait counter runs RD_LAT-1 down to 0; the sample happens in the cycle it reads 0.
   localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] wait_cnt;
   logic       accept;

   // Next-state logic; all control outputs are decoded directly from the current state.
   always_comb begin
      state_nxt                = state;
      cmd_ready                = (state == S_IDLE);
      busy                     = (state != S_IDLE);
      ctr_init                 = (state == S_INIT);
      ctr_return_current_count = (state == S_RD_WAIT);
      resp_valid               = (state == S_RESP);
      accept                   = cmd_valid & cmd_ready;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (cmd_funct == OP_INIT) begin
                  state_nxt = S_INIT;
               end else if (cmd_funct == OP_READ) begin
                  state_nxt = S_RD_WAIT;
               end
            end
         end
         S_INIT: begin
            state_nxt = S_IDLE;
         end
         S_RD_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; reset drops any pending read or response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command side effects, read wait countdown and count capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctr_init_val <= '0;
         ctr_start    <= 1'b0;
         resp_rd      <= 5'd0;
         resp_data    <= '0;
         wait_cnt     <= 4'd0;
      end else begin
         if (accept) begin
            case (cmd_funct)
               OP_INIT:  ctr_init_val <= cmd_rs1;
               OP_START: ctr_start    <= 1'b1;
               OP_STOP:  ctr_start    <= 1'b0;
               OP_READ: begin
                  resp_rd  <= cmd_rd;
                  wait_cnt <= WAIT_LOAD;
               end
            endcase
         end
         if (state == S_RD_WAIT) begin
            if (wait_cnt == 4'd0) begin
               resp_data <= ctr_current_count;
            end else begin
               wait_cnt <= wait_cnt - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - self-checking bench for counter_cmd_ctrl
module tb_counter_cmd_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Instance with RD_LAT = 1
   logic        reset, cv, cr, rv, rr, ini, st, rrc, bsy;
   logic [1:0]  fn;
   logic [63:0] rs1, rdata, iv, cnt;
   logic [4:0]  rd, rrd;

   // Instance with RD_LAT = 4
   logic        reset4, cv4, cr4, rv4, rr4, ini4, st4, rrc4, bsy4;
   logic [1:0]  fn4;
   logic [63:0] rs14, rdata4, iv4, cnt4;
   logic [4:0]  rd4, rrd4;

   counter_cmd_ctrl #(.xLen(64), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cv), .cmd_ready(cr), .cmd_funct(fn),
      .cmd_rs1(rs1), .cmd_rd(rd), .resp_valid(rv), .resp_ready(rr), .resp_rd(rrd),
      .resp_data(rdata), .ctr_init(ini), .ctr_init_val(iv), .ctr_start(st),
      .ctr_return_current_count(rrc), .ctr_current_count(cnt), .busy(bsy)
   );

   counter_cmd_ctrl #(.xLen(64), .RD_LAT(4)) dut4 (
      .clk(clk), .reset(reset4), .cmd_valid(cv4), .cmd_ready(cr4), .cmd_funct(fn4),
      .cmd_rs1(rs14), .cmd_rd(rd4), .resp_valid(rv4), .resp_ready(rr4), .resp_rd(rrd4),
      .resp_data(rdata4), .ctr_init(ini4), .ctr_init_val(iv4), .ctr_start(st4),
      .ctr_return_current_count(rrc4), .ctr_current_count(cnt4), .busy(bsy4)
   );

   // Counter models: load wins over count.
   initial begin
      cnt  = 64'd0;
      cnt4 = 64'd0;
   end
   always @(posedge clk) begin
      if (ini) cnt <= iv;
      else if (st) cnt <= cnt + 64'd1;
   end
   always @(posedge clk) begin
      if (ini4) cnt4 <= iv4;
      else if (st4) cnt4 <= cnt4 + 64'd1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        cv;
      logic [1:0]  fn;
      logic [63:0] rs1;
      logic [4:0]  rd;
      logic        rr;
      logic        e_cr;
      logic        e_st;
      logic        e_ini;
      logic        e_rrc;
      logic        e_rv;
      logic [63:0] e_iv;
      logic [4:0]  e_rd;
   } vec_t;

   function automatic vec_t mk(input logic c, input logic [1:0] f, input logic [63:0] r1,
                               input logic [4:0] d, input logic rdy, input logic ecr,
                               input logic est, input logic eini, input logic errc,
                               input logic erv, input logic [63:0] eiv, input logic [4:0] erd);
      vec_t v;
      v.cv = c; v.fn = f; v.rs1 = r1; v.rd = d; v.rr = rdy;
      v.e_cr = ecr; v.e_st = est; v.e_ini = eini; v.e_rrc = errc; v.e_rv = erv;
      v.e_iv = eiv; v.e_rd = erd;
      return v;
   endfunction

   vec_t        vt[14];
   logic [63:0] snap, d1, d2, hold_data;
   logic        saw_rv;

   initial begin
      reset = 1'b0; cv = 1'b0; fn = 2'd0; rs1 = 64'd0; rd = 5'd0; rr = 1'b0;
      reset4 = 1'b0; cv4 = 1'b0; fn4 = 2'd0; rs14 = 64'd0; rd4 = 5'd0; rr4 = 1'b0;

      // Inputs applied for one cycle, expected outputs after the following edge.
      vt[0]  = mk(1, 2'd0, 64'd75, 5'd0, 1, 0, 0, 1, 0, 0, 64'd75, 5'd0);
      vt[1]  = mk(0, 2'd0, 64'd0,  5'd0, 1, 1, 0, 0, 0, 0, 64'd75, 5'd0);
      vt[2]  = mk(1, 2'd1, 64'd0,  5'd0, 1, 1, 1, 0, 0, 0, 64'd75, 5'd0);
      vt[3]  = mk(1, 2'd1, 64'd0,  5'd0, 1, 1, 1, 0, 0, 0, 64'd75, 5'd0);
      vt[4]  = mk(1, 2'd2, 64'd0,  5'd0, 1, 1, 0, 0, 0, 0, 64'd75, 5'd0);
      vt[5]  = mk(1, 2'd2, 64'd0,  5'd0, 1, 1, 0, 0, 0, 0, 64'd75, 5'd0);
      vt[6]  = mk(1, 2'd1, 64'd0,  5'd0, 1, 1, 1, 0, 0, 0, 64'd75, 5'd0);
      vt[7]  = mk(0, 2'd0, 64'd0,  5'd0, 1, 1, 1, 0, 0, 0, 64'd75, 5'd0);
      vt[8]  = mk(1, 2'd3, 64'd0,  5'd7, 1, 0, 1, 0, 1, 0, 64'd75, 5'd7);
      vt[9]  = mk(0, 2'd0, 64'd0,  5'd0, 1, 0, 1, 0, 0, 1, 64'd75, 5'd7);
      vt[10] = mk(0, 2'd0, 64'd0,  5'd0, 1, 1, 1, 0, 0, 0, 64'd75, 5'd7);
      vt[11] = mk(1, 2'd0, 64'd5,  5'd0, 1, 0, 1, 1, 0, 0, 64'd5,  5'd7);
      vt[12] = mk(0, 2'd0, 64'd0,  5'd0, 1, 1, 1, 0, 0, 0, 64'd5,  5'd7);
      vt[13] = mk(1, 2'd2, 64'd0,  5'd0, 1, 1, 0, 0, 0, 0, 64'd5,  5'd7);

      // Reset held for two cycles
      step(); step();
      reset = 1'b1; reset4 = 1'b1;
      step();
      chk("rst cmd_ready", cr, 1);
      chk("rst busy", bsy, 0);
      chk("rst resp_valid", rv, 0);
      chk("rst resp_data", rdata, 0);
      chk("rst resp_rd", rrd, 0);
      chk("rst ctr_init", ini, 0);
      chk("rst ctr_init_val", iv, 0);
      chk("rst ctr_start", st, 0);
      chk("rst ctr_rcc", rrc, 0);
      chk("rst4 cmd_ready", cr4, 1);
      chk("rst4 ctr_rcc", rrc4, 0);

      // Table-driven single-cycle behaviour
      for (int i = 0; i < 14; i++) begin
         cv = vt[i].cv; fn = vt[i].fn; rs1 = vt[i].rs1; rd = vt[i].rd; rr = vt[i].rr;
         step();
         chk($sformatf("v%0d cmd_ready", i), cr, vt[i].e_cr);
         chk($sformatf("v%0d busy", i), bsy, !vt[i].e_cr);
         chk($sformatf("v%0d ctr_start", i), st, vt[i].e_st);
         chk($sformatf("v%0d ctr_init", i), ini, vt[i].e_ini);
         chk($sformatf("v%0d ctr_rcc", i), rrc, vt[i].e_rrc);
         chk($sformatf("v%0d resp_valid", i), rv, vt[i].e_rv);
         chk($sformatf("v%0d ctr_init_val", i), iv, vt[i].e_iv);
         chk($sformatf("v%0d resp_rd", i), rrd, vt[i].e_rd);
      end
      cv = 1'b0; rr = 1'b0;

      // INIT 75, START, 10 cycles, READ tag 7
      cv = 1'b1; fn = 2'd0; rs1 = 64'd75;
      step();
      cv = 1'b0;
      step();
      chk("init count", cnt, 75);
      cv = 1'b1; fn = 2'd1;
      step();
      cv = 1'b0;
      repeat (10) step();
      cv = 1'b1; fn = 2'd3; rd = 5'd7;
      step();
      chk("read rcc", rrc, 1);
      snap = cnt;
      cv = 1'b0;
      step();
      chk("read rcc one cycle", rrc, 0);
      chk("read resp_valid", rv, 1);
      chk("read resp_rd", rrd, 7);
      chk("read resp_data", rdata, snap);
      chk("read resp_data value", rdata, 86);
      hold_data = rdata;

      // Back-pressure with STOP offered
      cv = 1'b1; fn = 2'd2;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp%0d resp_valid", i), rv, 1);
         chk($sformatf("bp%0d resp_data", i), rdata, hold_data);
         chk($sformatf("bp%0d resp_rd", i), rrd, 7);
         chk($sformatf("bp%0d cmd_ready", i), cr, 0);
         chk($sformatf("bp%0d ctr_start", i), st, 1);
      end
      rr = 1'b1;
      step();
      chk("bp release resp_valid", rv, 0);
      chk("bp release cmd_ready", cr, 1);
      chk("bp stop not yet", st, 1);
      rr = 1'b0;
      step();
      chk("bp stop accepted", st, 0);
      cv = 1'b0;

      // Stopped counter read twice
      repeat (20) step();
      rr = 1'b1;
      cv = 1'b1; fn = 2'd3; rd = 5'd3;
      step();
      cv = 1'b0;
      step();
      chk("stop rd1 valid", rv, 1);
      chk("stop rd1 tag", rrd, 3);
      chk("stop rd1 data", rdata, cnt);
      d1 = rdata;
      step();
      chk("stop rd1 done", cr, 1);
      cv = 1'b1; rd = 5'd4;
      step();
      cv = 1'b0;
      step();
      chk("stop rd2 valid", rv, 1);
      chk("stop rd2 tag", rrd, 4);
      d2 = rdata;
      chk("stop rd2 equal", d2, d1);
      step();
      rr = 1'b0;

      // RD_LAT = 4 latency
      cv4 = 1'b1; fn4 = 2'd1;
      step();
      cv4 = 1'b0;
      repeat (3) step();
      rr4 = 1'b1;
      cv4 = 1'b1; fn4 = 2'd3; rd4 = 5'd9;
      for (int i = 1; i <= 4; i++) begin
         step();
         cv4 = 1'b0;
         chk($sformatf("lat4 c%0d rcc", i), rrc4, 1);
         chk($sformatf("lat4 c%0d resp_valid", i), rv4, 0);
         if (i == 4) snap = cnt4;
      end
      step();
      chk("lat4 rcc low", rrc4, 0);
      chk("lat4 resp_valid", rv4, 1);
      chk("lat4 resp_rd", rrd4, 9);
      chk("lat4 resp_data", rdata4, snap);
      step();
      chk("lat4 idle", cr4, 1);

      // Mid-read reset with RD_LAT = 4
      cv4 = 1'b1; fn4 = 2'd3; rd4 = 5'd11;
      step();
      cv4 = 1'b0;
      step();
      chk("mid rcc before reset", rrc4, 1);
      #2 reset4 = 1'b0;
      #1;
      chk("mid rcc", rrc4, 0);
      chk("mid ctr_start", st4, 0);
      chk("mid resp_valid", rv4, 0);
      chk("mid busy", bsy4, 0);
      step(); step();
      reset4 = 1'b1;
      saw_rv = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rv4) saw_rv = 1'b1;
      end
      chk("mid no response", saw_rv, 0);
      chk("mid cmd_ready", cr4, 1);
      chk("mid idle busy", bsy4, 0);
      chk("mid resp_rd", rrd4, 0);
      chk("mid ctr_start after", st4, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
